// File: rtl/tinyriscv_pkg.sv
// Shared type definitions for tinyriscv pipeline primitives.
package tinyriscv_pkg;

    typedef enum logic [1:0] {
        SKID_EMPTY,
        SKID_ONE,
        SKID_FULL
    } skid_state_e;

endpackage

// File: rtl/prim_endff.sv
// Enable D flip-flop with synchronous active-low reset to a parameterised default.
module prim_endff #(
    parameter int unsigned    DW      = 32,
    parameter logic [DW-1:0]  DEFAULT = '0
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          en_i,
    input  logic [DW-1:0] d_i,
    output logic [DW-1:0] q_o
);

    logic [DW-1:0] r_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_q <= DEFAULT;
        end else if (en_i) begin
            r_q <= d_i;
        end
    end

    assign q_o = r_q;

endmodule

// File: rtl/prim_skid_reg.sv
// Two-entry valid/ready skid buffer; ready is decoded from state only, so no
// combinational path exists from out_ready_i to in_ready_o.
module prim_skid_reg
    import tinyriscv_pkg::*;
#(
    parameter int unsigned    DW      = 32,
    parameter logic [DW-1:0]  DEFAULT = '0
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          flush_i,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [DW-1:0] din_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [DW-1:0] qout_o
);

    skid_state_e   r_state;
    skid_state_e   w_state_next;
    logic          w_in_fire;
    logic          w_out_fire;
    logic          w_main_en;
    logic          w_skid_en;
    logic [DW-1:0] w_main_d;
    logic [DW-1:0] w_skid_d;
    logic [DW-1:0] w_main_q;
    logic [DW-1:0] w_skid_q;

    assign out_valid_o = (r_state != SKID_EMPTY);
    assign in_ready_o  = (r_state != SKID_FULL);
    assign qout_o      = w_main_q;

    assign w_in_fire  = in_valid_i & in_ready_o;
    assign w_out_fire = out_valid_o & out_ready_i;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= SKID_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Flush overrides any handshake and reloads both entries with DEFAULT.
    always_comb begin
        w_state_next = r_state;
        w_main_en    = 1'b0;
        w_main_d     = din_i;
        w_skid_en    = 1'b0;
        w_skid_d     = din_i;
        if (flush_i) begin
            w_state_next = SKID_EMPTY;
            w_main_en    = 1'b1;
            w_main_d     = DEFAULT;
            w_skid_en    = 1'b1;
            w_skid_d     = DEFAULT;
        end else begin
            unique case (r_state)
                SKID_EMPTY: begin
                    if (w_in_fire) begin
                        w_main_en    = 1'b1;
                        w_state_next = SKID_ONE;
                    end
                end
                SKID_ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        w_main_en = 1'b1;
                    end else if (w_in_fire) begin
                        w_skid_en    = 1'b1;
                        w_state_next = SKID_FULL;
                    end else if (w_out_fire) begin
                        w_state_next = SKID_EMPTY;
                    end
                end
                SKID_FULL: begin
                    if (w_out_fire) begin
                        w_main_en    = 1'b1;
                        w_main_d     = w_skid_q;
                        w_state_next = SKID_ONE;
                    end
                end
                default: begin
                    w_state_next = SKID_EMPTY;
                end
            endcase
        end
    end

    prim_endff #(
        .DW      (DW),
        .DEFAULT (DEFAULT)
    ) u_main (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en_i   (w_main_en),
        .d_i    (w_main_d),
        .q_o    (w_main_q)
    );

    prim_endff #(
        .DW      (DW),
        .DEFAULT (DEFAULT)
    ) u_skid (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en_i   (w_skid_en),
        .d_i    (w_skid_d),
        .q_o    (w_skid_q)
    );

endmodule

// File: tb/tb_prim_skid_reg.sv
// Self-checking bench for prim_skid_reg: directed vector table, reset corner
// case, and a randomised run against a reference queue.
module tb_prim_skid_reg;

    localparam int unsigned    DW  = 32;
    localparam logic [DW-1:0]  DEF = 32'hDEAD_BEEF;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          flush_i;
    logic          in_valid_i;
    logic          in_ready_o;
    logic [DW-1:0] din_i;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [DW-1:0] qout_o;

    int checks = 0;
    int errors = 0;

    prim_skid_reg #(
        .DW      (DW),
        .DEFAULT (DEF)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .din_i       (din_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .qout_o      (qout_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic          flush;
        logic          iv;
        logic [DW-1:0] din;
        logic          ordy;
        logic          ev;
        logic          er;
        logic [DW-1:0] eq;
    } vec_t;

    vec_t vecs[18];
    logic [DW-1:0] sb[$];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_out(input string tag, input logic ev, input logic er, input logic [DW-1:0] eq);
        chk({tag, ".valid"}, {31'd0, out_valid_o}, {31'd0, ev});
        chk({tag, ".ready"}, {31'd0, in_ready_o}, {31'd0, er});
        chk({tag, ".qout"}, qout_o, eq);
    endtask

    task automatic drive(input logic fl, input logic iv, input logic [DW-1:0] d, input logic ordy);
        flush_i     = fl;
        in_valid_i  = iv;
        din_i       = d;
        out_ready_i = ordy;
    endtask

    function automatic vec_t mk(input logic fl, input logic iv, input logic [DW-1:0] d,
                                input logic ordy, input logic ev, input logic er,
                                input logic [DW-1:0] eq);
        vec_t v;
        v.flush = fl; v.iv = iv; v.din = d; v.ordy = ordy;
        v.ev = ev; v.er = er; v.eq = eq;
        return v;
    endfunction

    initial begin
        logic          in_fire;
        logic          out_fire;
        logic          prev_hold;
        logic [DW-1:0] prev_q;

        // Each row: inputs applied for one cycle, outputs expected after that edge.
        vecs[0]  = mk(0, 0, 32'h0,    0, 0, 1, DEF);     // idle after reset
        vecs[1]  = mk(0, 1, 32'h1,    1, 1, 1, 32'h1);   // stream 1
        vecs[2]  = mk(0, 1, 32'h2,    1, 1, 1, 32'h2);   // stream 2
        vecs[3]  = mk(0, 1, 32'h3,    1, 1, 1, 32'h3);   // stream 3
        vecs[4]  = mk(0, 0, 32'h0,    1, 0, 1, 32'h3);   // drain, main holds
        vecs[5]  = mk(0, 1, 32'hA,    0, 1, 1, 32'hA);   // push A, stalled
        vecs[6]  = mk(0, 1, 32'hB,    0, 1, 0, 32'hA);   // push B -> full
        vecs[7]  = mk(0, 1, 32'hC,    0, 1, 0, 32'hA);   // C held off
        vecs[8]  = mk(0, 1, 32'hC,    1, 1, 1, 32'hB);   // A out, C still refused
        vecs[9]  = mk(0, 1, 32'hC,    1, 1, 1, 32'hC);   // B out, C in
        vecs[10] = mk(0, 0, 32'h0,    1, 0, 1, 32'hC);   // C out
        vecs[11] = mk(0, 1, 32'hA,    0, 1, 1, 32'hA);
        vecs[12] = mk(0, 1, 32'hB,    0, 1, 0, 32'hA);
        vecs[13] = mk(1, 1, 32'hD,    1, 0, 1, DEF);     // flush when full, D dropped
        vecs[14] = mk(0, 0, 32'h0,    1, 0, 1, DEF);
        vecs[15] = mk(0, 1, 32'h5,    0, 1, 1, 32'h5);
        vecs[16] = mk(1, 1, 32'h6,    0, 0, 1, DEF);     // flush in ONE
        vecs[17] = mk(0, 1, 32'h7,    1, 1, 1, 32'h7);

        rst_ni = 1'b0;
        drive(0, 0, '0, 0);
        repeat (2) @(posedge clk_i);
        #1;
        chk_out("reset", 1'b0, 1'b1, DEF);
        rst_ni = 1'b1;

        for (int i = 0; i < 18; i++) begin
            drive(vecs[i].flush, vecs[i].iv, vecs[i].din, vecs[i].ordy);
            @(posedge clk_i);
            #1;
            chk_out($sformatf("vec%0d", i), vecs[i].ev, vecs[i].er, vecs[i].eq);
        end

        // Reset while full.
        drive(0, 0, '0, 1);
        @(posedge clk_i); #1;
        drive(0, 1, 32'hA, 0);
        @(posedge clk_i); #1;
        drive(0, 1, 32'hB, 0);
        @(posedge clk_i); #1;
        chk_out("prerst_full", 1'b1, 1'b0, 32'hA);
        rst_ni = 1'b0;
        drive(0, 1, 32'hD, 1);
        @(posedge clk_i); #1;
        chk_out("rst_full", 1'b0, 1'b1, DEF);
        rst_ni = 1'b1;
        drive(0, 1, 32'h5, 0);
        @(posedge clk_i); #1;
        chk_out("rst_push5", 1'b1, 1'b1, 32'h5);
        drive(0, 0, '0, 1);
        @(posedge clk_i); #1;
        chk_out("rst_drain", 1'b0, 1'b1, 32'h5);

        // Random traffic against a reference queue.
        sb.delete();
        prev_hold = 1'b0;
        prev_q    = '0;
        for (int c = 0; c < 10000; c++) begin
            drive(1'b0, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
            @(negedge clk_i);
            if (prev_hold && out_valid_o) chk("stable", qout_o, prev_q);
            in_fire  = in_valid_i && (sb.size() < 2);
            out_fire = out_ready_i && (sb.size() > 0);
            if (out_fire) chk("sb_data", qout_o, sb[0]);
            prev_hold = out_valid_o && !out_ready_i;
            prev_q    = qout_o;
            @(posedge clk_i);
            if (out_fire) void'(sb.pop_front());
            if (in_fire) sb.push_back(din_i);
            #1;
            chk("rnd_valid", {31'd0, out_valid_o}, {31'd0, sb.size() != 0});
            chk("rnd_ready", {31'd0, in_ready_o}, {31'd0, sb.size() < 2});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
